// File: rtl/aes_result_collector.sv
// aes_result_collector
//   Output-side receiver for the AES round pipeline. Every cycle it samples the
//   result and job type from the last-round stage. Valid ENCRYPT/DECRYPT results
//   are buffered in a DEPTH-entry FIFO. Each block is streamed to the host as
//   four 32-bit beats, most significant word first. The round pipeline cannot
//   stall, so almost_full tells the injector to stop issuing jobs. A result that
//   arrives while the FIFO is full, with no pop in the same cycle, is dropped
//   and counted.
//
// Ports:
//   clk           clock, rising edge
//   rst_n         asynchronous active-low reset
//   in_block      128-bit result from the last-round stage
//   in_type       job type; only ENCRYPT/DECRYPT results are stored
//   almost_full   back-pressure to the injector (count >= DEPTH-SLACK)
//   overflow      sticky flag, set when a valid result was dropped
//   overflow_clr  synchronous clear of overflow and drop_cnt
//   drop_cnt      saturating count of dropped results
//   out_word      current beat of the head block
//   out_dir       head job type: 1 = DECRYPT, 0 = ENCRYPT
//   out_last      high on beat 3
//   out_valid     head beat available
//   out_ready     consumer accepts the beat

package aes_sysdef_pkg;
    typedef enum logic [1:0] {
        JOB_INVALID = 2'b00,
        JOB_ENCRYPT = 2'b01,
        JOB_DECRYPT = 2'b10
    } job_t;
endpackage

module aes_result_collector
    import aes_sysdef_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int SLACK = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [127:0] in_block,
    input  job_t         in_type,
    output logic         almost_full,
    output logic         overflow,
    input  logic         overflow_clr,
    output logic [7:0]   drop_cnt,
    output logic [31:0]  out_word,
    output logic         out_dir,
    output logic         out_last,
    output logic         out_valid,
    input  logic         out_ready
);

    localparam int AW = $clog2(DEPTH);

    // Each entry holds {block[127:0], dir}.
    logic [128:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic [1:0]    beat;

    logic          push;
    logic          pop;
    logic          full;
    logic          wr_en;
    logic          drop;
    logic [128:0]  head;

    assign push  = (in_type == JOB_ENCRYPT) || (in_type == JOB_DECRYPT);
    assign full  = (count == (AW+1)'(DEPTH));
    assign pop   = out_valid && out_ready && (beat == 2'd3);
    // When full, a pop in the same cycle frees the slot for the incoming result.
    assign wr_en = push && (!full || pop);
    assign drop  = push && full && !pop;

    assign out_valid   = (count != '0);
    assign almost_full = (count >= (AW+1)'(DEPTH - SLACK));

    assign head = mem[rd_ptr];

    always_comb begin
        out_word = '0;
        out_dir  = 1'b0;
        out_last = 1'b0;
        if (out_valid) begin
            out_dir  = head[0];
            out_last = (beat == 2'd3);
            case (beat)
                2'd0:    out_word = head[128:97];
                2'd1:    out_word = head[96:65];
                2'd2:    out_word = head[64:33];
                default: out_word = head[32:1];
            endcase
        end
    end

    // Storage is not reset; count/pointers define what is valid.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= {in_block, (in_type == JOB_DECRYPT)};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            beat   <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (out_valid && out_ready) begin
                beat <= beat + 2'd1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({wr_en, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // A drop in the same cycle as a clear wins, leaving a count of one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow <= 1'b0;
            drop_cnt <= '0;
        end else if (drop) begin
            overflow <= 1'b1;
            if (overflow_clr) begin
                drop_cnt <= 8'd1;
            end else if (drop_cnt != 8'hFF) begin
                drop_cnt <= drop_cnt + 8'd1;
            end
        end else if (overflow_clr) begin
            overflow <= 1'b0;
            drop_cnt <= '0;
        end
    end

endmodule

// File: tb/tb_aes_result_collector.sv
// tb_aes_result_collector
//   Self-checking bench for aes_result_collector: a table of vectors for the
//   single-block case, hand-written sequences for the multi-cycle corners, and a
//   randomized phase, all checked every cycle against a queue-based model.

module tb_aes_result_collector;
    import aes_sysdef_pkg::*;

    localparam int DEPTH = 4;
    localparam int SLACK = 2;

    logic         clk;
    logic         rst_n;
    logic [127:0] in_block;
    job_t         in_type;
    logic         almost_full;
    logic         overflow;
    logic         overflow_clr;
    logic [7:0]   drop_cnt;
    logic [31:0]  out_word;
    logic         out_dir;
    logic         out_last;
    logic         out_valid;
    logic         out_ready;

    aes_result_collector #(.DEPTH(DEPTH), .SLACK(SLACK)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_block     (in_block),
        .in_type      (in_type),
        .almost_full  (almost_full),
        .overflow     (overflow),
        .overflow_clr (overflow_clr),
        .drop_cnt     (drop_cnt),
        .out_word     (out_word),
        .out_dir      (out_dir),
        .out_last     (out_last),
        .out_valid    (out_valid),
        .out_ready    (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: a queue of {block, dir} plus the beat position.
    logic [128:0] mq[$];
    int           mbeat;
    logic         mof;
    int           mdc;

    // Blocks reassembled from accepted DUT beats.
    logic [127:0] rx_acc;
    logic [127:0] rx_blocks[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic check_all();
        logic [127:0] blk;
        logic [31:0]  w;
        logic         d, l, v;
        w = '0; d = 1'b0; l = 1'b0; v = 1'b0;
        if (mq.size() != 0) begin
            blk = mq[0][128:1];
            w   = blk[127 - 32*mbeat -: 32];
            d   = mq[0][0];
            l   = (mbeat == 3);
            v   = 1'b1;
        end
        chk("out_valid",   32'(out_valid),   32'(v));
        chk("out_word",    out_word,         w);
        chk("out_dir",     32'(out_dir),     32'(d));
        chk("out_last",    32'(out_last),    32'(l));
        chk("almost_full", 32'(almost_full), 32'(mq.size() >= DEPTH - SLACK));
        chk("overflow",    32'(overflow),    32'(mof));
        chk("drop_cnt",    32'(drop_cnt),    32'(mdc));
    endtask

    task automatic model_update();
        bit p, pop, drop, adv;
        p    = (in_type == JOB_ENCRYPT) || (in_type == JOB_DECRYPT);
        adv  = (mq.size() > 0) && out_ready;
        pop  = adv && (mbeat == 3);
        drop = p && (mq.size() == DEPTH) && !pop;
        if (adv) begin
            if (mbeat == 3) begin
                void'(mq.pop_front());
                mbeat = 0;
            end else begin
                mbeat++;
            end
        end
        if (p && !drop) mq.push_back({in_block, in_type == JOB_DECRYPT});
        if (drop) begin
            mof = 1'b1;
            mdc = overflow_clr ? 1 : ((mdc < 255) ? mdc + 1 : 255);
        end else if (overflow_clr) begin
            mof = 1'b0;
            mdc = 0;
        end
    endtask

    task automatic drive(input job_t t, input logic [127:0] blk, input logic rdy, input logic clr);
        in_type      = t;
        in_block     = blk;
        out_ready    = rdy;
        overflow_clr = clr;
    endtask

    // One clock: record the DUT beat being accepted, advance model, check.
    task automatic step();
        if (out_valid && out_ready) begin
            rx_acc = {rx_acc[95:0], out_word};
            if (out_last) rx_blocks.push_back(rx_acc);
        end
        @(posedge clk);
        model_update();
        #1;
        check_all();
    endtask

    task automatic idle(input int n, input logic rdy);
        drive(JOB_INVALID, '0, rdy, 1'b0);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        mq.delete();
        mbeat = 0;
        mof   = 1'b0;
        mdc   = 0;
        check_all();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    typedef struct {
        job_t         t;
        logic [127:0] blk;
        logic         rdy;
        logic [31:0]  e_word;
        logic         e_valid;
        logic         e_last;
        logic         e_dir;
    } vec_t;

    vec_t vecs[5];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] blk_a, blk_b, blk_c, s0, r1, f4;
        logic [127:0] pb[5];
        logic [127:0] fb[4];

        rx_acc = '0;
        drive(JOB_INVALID, '0, 1'b1, 1'b0);
        rst_n = 1'b1;
        #2;
        do_reset();

        // Single encrypt, table-driven.
        vecs[0] = '{JOB_ENCRYPT, 128'h00112233_44556677_8899AABB_CCDDEEFF, 1'b1, 32'h00112233, 1'b1, 1'b0, 1'b0};
        vecs[1] = '{JOB_INVALID, 128'h0, 1'b1, 32'h44556677, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{JOB_INVALID, 128'h0, 1'b1, 32'h8899AABB, 1'b1, 1'b0, 1'b0};
        vecs[3] = '{JOB_INVALID, 128'h0, 1'b1, 32'hCCDDEEFF, 1'b1, 1'b1, 1'b0};
        vecs[4] = '{JOB_INVALID, 128'h0, 1'b1, 32'h00000000, 1'b0, 1'b0, 1'b0};
        for (int i = 0; i < 5; i++) begin
            drive(vecs[i].t, vecs[i].blk, vecs[i].rdy, 1'b0);
            step();
            chk("vec_word",  out_word,          vecs[i].e_word);
            chk("vec_valid", 32'(out_valid),    32'(vecs[i].e_valid));
            chk("vec_last",  32'(out_last),     32'(vecs[i].e_last));
            chk("vec_dir",   32'(out_dir),      32'(vecs[i].e_dir));
        end

        // Type filtering: the INVALID block never appears.
        rx_blocks.delete();
        blk_a = 128'hA0A0A0A0_A1A1A1A1_A2A2A2A2_A3A3A3A3;
        blk_b = 128'hB0B0B0B0_B1B1B1B1_B2B2B2B2_B3B3B3B3;
        blk_c = 128'hC0C0C0C0_C1C1C1C1_C2C2C2C2_C3C3C3C3;
        drive(JOB_DECRYPT, blk_a, 1'b1, 1'b0); step();
        drive(JOB_INVALID, blk_b, 1'b1, 1'b0); step();
        drive(JOB_DECRYPT, blk_c, 1'b1, 1'b0); step();
        idle(10, 1'b1);
        chk("filter_count", 32'(rx_blocks.size()), 32'd2);
        if (rx_blocks.size() == 2) begin
            chk("filter_first",  rx_blocks[0][127:96], blk_a[127:96]);
            chk("filter_second", rx_blocks[1][127:96], blk_c[127:96]);
            chk("filter_second_lsw", rx_blocks[1][31:0], blk_c[31:0]);
        end

        // Back-pressure and overflow.
        rx_blocks.delete();
        for (int i = 0; i < 5; i++) pb[i] = {4{32'h1000_0000 + 32'(i)}};
        for (int i = 0; i < 5; i++) begin
            drive(JOB_ENCRYPT, pb[i], 1'b0, 1'b0);
            step();
            if (i == 0) chk("af_at_1", 32'(almost_full), 32'd0);
            if (i == 1) chk("af_at_2", 32'(almost_full), 32'd1);
        end
        chk("bp_overflow", 32'(overflow), 32'd1);
        chk("bp_drop_cnt", 32'(drop_cnt), 32'd1);
        idle(20, 1'b1);
        chk("bp_drain_count", 32'(rx_blocks.size()), 32'd4);
        for (int i = 0; i < 4 && i < rx_blocks.size(); i++)
            chk("bp_drain_order", rx_blocks[i][31:0], pb[i][31:0]);

        // Full with simultaneous push/pop.
        drive(JOB_INVALID, '0, 1'b0, 1'b1);
        step();
        chk("clr_overflow", 32'(overflow), 32'd0);
        rx_blocks.delete();
        for (int i = 0; i < 4; i++) begin
            fb[i] = {4{32'h2000_0000 + 32'(i)}};
            drive(JOB_ENCRYPT, fb[i], 1'b0, 1'b0);
            step();
        end
        idle(3, 1'b1);
        chk("pp_on_beat3", 32'(out_last), 32'd1);
        f4 = 128'hF4F4F4F4_F5F5F5F5_F6F6F6F6_F7F7F7F7;
        drive(JOB_DECRYPT, f4, 1'b1, 1'b0);
        step();
        chk("pp_no_drop",  32'(overflow), 32'd0);
        chk("pp_drop_cnt", 32'(drop_cnt), 32'd0);
        chk("pp_still_af", 32'(almost_full), 32'd1);
        idle(20, 1'b1);
        chk("pp_count", 32'(rx_blocks.size()), 32'd5);
        if (rx_blocks.size() == 5) chk("pp_last_block", rx_blocks[4][63:32], f4[63:32]);

        // Stall mid-block on beat 2.
        s0 = 128'h51515151_52525252_53535353_54545454;
        drive(JOB_ENCRYPT, s0, 1'b1, 1'b0);
        step();
        idle(2, 1'b1);
        drive(JOB_INVALID, '0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_hold", out_word, 32'h53535353);
        end
        drive(JOB_INVALID, '0, 1'b1, 1'b0);
        step();
        chk("stall_resume", out_word, 32'h54545454);
        chk("stall_last",   32'(out_last), 32'd1);
        idle(2, 1'b1);

        // Reset during beat 1, then a new block starts at beat 0.
        drive(JOB_ENCRYPT, 128'hDEADBEEF_CAFEF00D_01234567_89ABCDEF, 1'b1, 1'b0);
        step();
        idle(1, 1'b1);
        chk("pre_reset_beat1", out_word, 32'hCAFEF00D);
        do_reset();
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_word",  out_word, 32'd0);
        r1 = 128'h77777777_88888888_99999999_AAAAAAAA;
        drive(JOB_DECRYPT, r1, 1'b0, 1'b0);
        step();
        chk("post_rst_beat0", out_word, 32'h77777777);
        chk("post_rst_dir",   32'(out_dir), 32'd1);
        for (int i = 0; i < 4; i++) begin
            drive(JOB_ENCRYPT, {4{32'h3000_0000 + 32'(i)}}, 1'b0, 1'b0);
            step();
        end
        chk("rst_seq_overflow", 32'(overflow), 32'd1);
        drive(JOB_INVALID, '0, 1'b0, 1'b1);
        step();
        chk("clr_after_rst_of", 32'(overflow), 32'd0);
        chk("clr_after_rst_dc", 32'(drop_cnt), 32'd0);
        // Drop and clear in the same cycle: the drop wins.
        drive(JOB_ENCRYPT, '1, 1'b0, 1'b1);
        step();
        chk("drop_beats_clr_of", 32'(overflow), 32'd1);
        chk("drop_beats_clr_dc", 32'(drop_cnt), 32'd1);
        // Saturation at 255.
        drive(JOB_DECRYPT, '1, 1'b0, 1'b0);
        for (int i = 0; i < 260; i++) step();
        chk("drop_saturate", 32'(drop_cnt), 32'd255);
        idle(20, 1'b1);

        // Randomized traffic against the model.
        for (int i = 0; i < 2000; i++) begin
            int r;
            job_t t;
            r = $urandom_range(0, 9);
            if (r < 3)      t = JOB_ENCRYPT;
            else if (r < 6) t = JOB_DECRYPT;
            else if (r < 9) t = JOB_INVALID;
            else            t = job_t'(2'b11);
            drive(t, {$urandom, $urandom, $urandom, $urandom},
                  logic'($urandom_range(0, 9) < 7), logic'($urandom_range(0, 19) == 0));
            step();
        end
        idle(24, 1'b1);
        chk("final_empty", 32'(out_valid), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/aes_result_collector.md
# aes_result_collector

Output-side receiver for the AES round pipeline. Every cycle it samples the registered 128-bit result and job type produced by the last-round stage. It buffers valid ENCRYPT/DECRYPT results in a small FIFO and streams each block to the host side as four 32-bit beats over a valid/ready handshake. The round pipeline cannot stall, so the block tells the upstream injector when to stop issuing jobs and flags any result dropped on overflow.

## Interface

Parameters:
- DEPTH, 4: FIFO entries, power of two, ≥2.
- SLACK, 2: results that can still be in flight after the injector stops; almost_full asserts when count ≥ DEPTH−SLACK.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- in_block  in  128  result from last-round stage.
- in_type  in  job_t  ENCRYPT / DECRYPT / INVALID, from sysdef.svh.
- almost_full  out  1  back-pressure to the job injector.
- overflow  out  1  sticky flag, set when a valid result was dropped.
- overflow_clr  in  1  synchronous clear of overflow and drop_cnt.
- drop_cnt  out  8  saturating count of dropped results.
- out_word  out  32  current beat of the head block.
- out_dir  out  1  head job type: 1 = DECRYPT, 0 = ENCRYPT.
- out_last  out  1  high on the final beat (beat 3).
- out_valid  out  1  head beat available.
- out_ready  in  1  consumer accepts the beat.

## Operation

- Push: in_type is ENCRYPT or DECRYPT → write {in_block, dir} at wr_ptr.
  - INVALID and any other encoding → ignored, no state change.
- Storage: FIFO of DEPTH entries of 129 bits (block plus dir).
  - Pointers are log2(DEPTH) bits and wrap modulo DEPTH.
  - count is log2(DEPTH)+1 bits, range 0..DEPTH.
- Serialization: beat counter beat[1:0] indexes the head entry, MSW first.
  - beat 0 → bits 127:96, beat 1 → 95:64, beat 2 → 63:32, beat 3 → 31:0.
  - out_word, out_dir and out_last are combinational from the head entry and beat.
- Beat handshake: out_valid && out_ready at a clock edge → beat increments.
  - On beat 3: beat → 0, the entry is popped and rd_ptr advances.
- out_valid = (count != 0).
  - When count = 0, out_word, out_dir and out_last are 0.
- Consumer rule: once out_valid is high, out_word, out_dir and out_last hold stable until the beat is accepted.
- Simultaneous push and pop in the same cycle:
  - count is unchanged.
  - When full, the push is accepted because the slot is freed that cycle.
- Overflow: push while count = DEPTH and no pop that cycle →
  - result is dropped and FIFO contents are unchanged;
  - overflow ← 1;
  - drop_cnt increments, saturating at 255.
- overflow_clr: overflow ← 0 and drop_cnt ← 0.
  - If a drop occurs in the same cycle, the drop wins: overflow = 1, drop_cnt = 1.
- almost_full = (count ≥ DEPTH−SLACK), combinational from the registered count.

## Timing

- Reset values: all pointers, count, beat, overflow and drop_cnt are 0.
  - As a result, out_valid = 0, almost_full = 0, out_word = 0, out_dir = 0 and out_last = 0 in reset.
- Reset asserted mid-transfer: the FIFO is emptied and a partially sent block is discarded.
  - After release, the next block starts at beat 0.
- Latency: a result sampled at edge N gives out_valid = 1 and beat 0 on out_word after edge N, when the FIFO was empty.
- Throughput: with out_ready held high, one block every 4 cycles.
  - A back-to-back result stream therefore fills the FIFO; the injector is responsible for honoring almost_full.
- No combinational path from out_ready to out_valid, or from in_type to any output.

## Test plan

- Single encrypt: one cycle of in_type=ENCRYPT, in_block=128'h00112233_44556677_8899AABB_CCDDEEFF, out_ready=1 → next four cycles carry out_word 00112233, 44556677, 8899AABB, CCDDEEFF.
  - out_dir = 0 throughout; out_last is high only on the fourth beat; out_valid is then 0.
- Type filtering: in the sequence DECRYPT(A), INVALID(B), DECRYPT(C) → only A then C appear, both with out_dir = 1. Block B never appears.
- Back-pressure: out_ready=0 with 4 results pushed (DEPTH=4) →
  - almost_full rises once count reaches 2;
  - a 5th push sets overflow = 1 and drop_cnt = 1;
  - released out_ready drains exactly the first 4 blocks, in order.
- Full with simultaneous push/pop: FIFO full, out_ready=1 on beat 3 while a new result arrives →
  - no drop, count stays 4;
  - the new block is delivered last.
- Stall mid-block: deassert out_ready on beat 2 for 3 cycles → out_word holds the beat-2 value, then resumes with beat 3 in order.
- Reset mid-block: rst_n low during beat 1 → outputs are 0 immediately; a new result after release starts at beat 0; overflow_clr then clears a previously set overflow.
